// File: rtl/ts_bus_if.sv
// Bundle of requester-side and slave-side signals shared by ts_bus_sequencer.
// master: the sequencer's view; slave: the requesters/slaves environment view.
interface ts_bus_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [8*N-1:0] req_adrs;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           rdata;
  logic [7:0]     bus_adrs;
  logic           bus_data;

  modport master (
    input  req, req_adrs, bus_data,
    output gnt, done, rdata, bus_adrs
  );

  modport slave (
    output req, req_adrs, bus_data,
    input  gnt, done, rdata, bus_adrs
  );
endinterface

// File: rtl/ts_bus_sequencer.sv
// Round-robin owner of the shared tristate bus: grants one requester, holds its
// address SETTLE cycles, samples bus_data. Define TS_SEQ_PARK_EN for a parked TURN cycle.
module ts_bus_sequencer #(
  parameter int         N         = 4,
  parameter int         SETTLE    = 2,
  parameter logic [7:0] IDLE_ADRS = 8'hFF
) (
  input  logic      clk,
  input  logic      rst,
  ts_bus_if.master  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
`ifdef TS_SEQ_PARK_EN
  localparam logic [1:0] S_TURN = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          rdata_q, rdata_d;
  logic [7:0]    adrs_q, adrs_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          found;
  logic [PW-1:0] pick;
  int            scan;

  // First active requester at or after ptr, wrapping at N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = 0;
    for (int k = 0; k < N; k++) begin
      scan = (int'(ptr_q) + k) % N;
      if (!found && bus.req[scan]) begin
        found = 1'b1;
        pick  = PW'(scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    adrs_d  = adrs_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          adrs_d       = bus.req_adrs[8*int'(pick) +: 8];
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          idx_d        = pick;
          cnt_d        = 4'(SETTLE - 1);
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) begin
          rdata_d = bus.bus_data;
          done_d  = gnt_q;
          gnt_d   = '0;
          adrs_d  = IDLE_ADRS;
          ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
`ifdef TS_SEQ_PARK_EN
          state_d = S_TURN;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef TS_SEQ_PARK_EN
      // Bus stays parked one full cycle so no two slaves ever overlap on the wire.
      S_TURN: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= 1'b0;
      adrs_q  <= IDLE_ADRS;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      adrs_q  <= adrs_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.bus_adrs = adrs_q;
endmodule

// File: tb/tb_ts_bus_sequencer.sv
// Directed bench for ts_bus_sequencer with N=2, SETTLE=2, slaves at 50 and 42.
module tb_ts_bus_sequencer;
`ifdef TS_SEQ_PARK_EN
  localparam int SP = 4;
`else
  localparam int SP = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s50 = 1'b0;
  logic s42 = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  ts_bus_if #(.N(2)) bus_if ();

  ts_bus_sequencer #(.N(2), .SETTLE(2), .IDLE_ADRS(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  assign bus_if.bus_data = (bus_if.bus_adrs == 8'd50) ? s50 :
                           (bus_if.bus_adrs == 8'd42) ? s42 : 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req = 2'b00;
    bus_if.req_adrs = {8'd42, 8'd50};
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] gseq [3];
  int         gcyc [3];
  logic       rseq [3];
  logic [1:0] ga   [24];
  logic [7:0] ba   [24];
  int         ng, nr;
  logic [1:0] prev_g;

  initial begin
    bus_if.req = 2'b00;
    bus_if.req_adrs = {8'd42, 8'd50};

    // Reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle_adrs", 32'(bus_if.bus_adrs), 32'hFF);
      check("idle_gnt", 32'(bus_if.gnt), 32'h0);
      check("idle_done", 32'(bus_if.done), 32'h0);
      tick();
    end
    check("idle_rdata", 32'(bus_if.rdata), 32'h0);

    // Single transfer from requester 0 to slave 50
    s50 = 1'b1; s42 = 1'b0;
    bus_if.req = 2'b01;
    tick();
    bus_if.req = 2'b00;
    check("t1_gnt", 32'(bus_if.gnt), 32'h1);
    check("t1_adrs", 32'(bus_if.bus_adrs), 32'd50);
    check("t1_done", 32'(bus_if.done), 32'h0);
    tick();
    check("t2_gnt", 32'(bus_if.gnt), 32'h1);
    check("t2_adrs", 32'(bus_if.bus_adrs), 32'd50);
    tick();
    check("t3_done", 32'(bus_if.done), 32'h1);
    check("t3_rdata", 32'(bus_if.rdata), 32'h1);
    check("t3_adrs", 32'(bus_if.bus_adrs), 32'hFF);
    check("t3_gnt", 32'(bus_if.gnt), 32'h0);
    tick();
    check("t4_done", 32'(bus_if.done), 32'h0);
    check("t4_rdata_hold", 32'(bus_if.rdata), 32'h1);

    // Both requesting: round-robin alternation
    do_reset();
    s50 = 1'b1; s42 = 1'b0;
    bus_if.req = 2'b11;
    ng = 0; nr = 0; prev_g = 2'b00;
    for (int i = 0; i < 3; i++) begin gseq[i] = 2'b00; gcyc[i] = 0; rseq[i] = 1'bx; end
    for (int c = 1; c < 24; c++) begin
      tick();
      ga[c] = bus_if.gnt;
      ba[c] = bus_if.bus_adrs;
      if (bus_if.gnt != 2'b00 && prev_g == 2'b00 && ng < 3) begin
        gseq[ng] = bus_if.gnt; gcyc[ng] = c; ng++;
      end
      if (bus_if.done != 2'b00 && nr < 3) begin
        rseq[nr] = bus_if.rdata; nr++;
      end
      prev_g = bus_if.gnt;
    end
    bus_if.req = 2'b00;
    check("rr_g0", 32'(gseq[0]), 32'h1);
    check("rr_g1", 32'(gseq[1]), 32'h2);
    check("rr_g2", 32'(gseq[2]), 32'h1);
    check("rr_first_cyc", 32'(gcyc[0]), 32'd1);
    check("rr_space01", 32'(gcyc[1] - gcyc[0]), 32'(SP));
    check("rr_space12", 32'(gcyc[2] - gcyc[1]), 32'(SP));
    check("rr_r0", 32'(rseq[0]), 32'h1);
    check("rr_r1", 32'(rseq[1]), 32'h0);
    check("rr_r2", 32'(rseq[2]), 32'h1);
    for (int i = 1; i < 3; i++) begin
      if (gcyc[i] > 1) begin
        check("rr_gap_adrs", 32'(ba[gcyc[i] - 1]), 32'hFF);
        check("rr_gap_gnt", 32'(ga[gcyc[i] - 1]), 32'h0);
`ifdef TS_SEQ_PARK_EN
        check("rr_park_adrs", 32'(ba[gcyc[i] - 2]), 32'hFF);
        check("rr_park_gnt", 32'(ga[gcyc[i] - 2]), 32'h0);
`endif
      end else begin
        check("rr_grant_seen", 32'(gcyc[i]), 32'd99);
      end
    end

    // Address change and req drop mid-transfer
    do_reset();
    s50 = 1'b1; s42 = 1'b0;
    bus_if.req = 2'b01;
    tick();
    bus_if.req_adrs = {8'd42, 8'd42};
    bus_if.req = 2'b00;
    check("hold_t1_adrs", 32'(bus_if.bus_adrs), 32'd50);
    tick();
    check("hold_t2_adrs", 32'(bus_if.bus_adrs), 32'd50);
    check("hold_t2_gnt", 32'(bus_if.gnt), 32'h1);
    tick();
    check("hold_t3_done", 32'(bus_if.done), 32'h1);
    check("hold_t3_rdata", 32'(bus_if.rdata), 32'h1);

    // Reset mid-transfer
    do_reset();
    s50 = 1'b1; s42 = 1'b0;
    bus_if.req = 2'b10;
    tick();
    check("abort_t1_gnt", 32'(bus_if.gnt), 32'h2);
    check("abort_t1_adrs", 32'(bus_if.bus_adrs), 32'd42);
    tick();
    rst = 1'b1;
    tick();
    check("abort_done", 32'(bus_if.done), 32'h0);
    check("abort_gnt", 32'(bus_if.gnt), 32'h0);
    check("abort_adrs", 32'(bus_if.bus_adrs), 32'hFF);
    check("abort_rdata", 32'(bus_if.rdata), 32'h0);
    rst = 1'b0;
    bus_if.req = 2'b11;
    tick();
    check("abort_next_gnt", 32'(bus_if.gnt), 32'h1);
    check("abort_next_adrs", 32'(bus_if.bus_adrs), 32'd50);
    bus_if.req = 2'b00;
    tick();
    tick();
    check("abort_next_done", 32'(bus_if.done), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
